qam16_frame_scheduler: RTL and testbench

- Sequences the 16-QAM symbol mapper: accepts payload bytes over a valid/ready stream and splits each byte into two 4-bit symbols, MSB nibble first.
- Prepends a fixed preamble to every frame and issues one symbol every SYM_DIV clocks.
- Sits directly upstream of the mapper: sym drives the mapper's 4-bit input, and map_valid marks cycles where the mapper's registered outR/outI carry a valid frame symbol.

---
 rtl/qam16_frame_scheduler.sv | 155 +++++++++++++++
 tb/tb_qam16_frame_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_frame_scheduler.sv
// qam16_frame_scheduler
//   Feeds a 16-QAM symbol mapper. Each frame starts with a fixed preamble.
//   After the preamble, each payload byte is sent as two 4-bit symbols,
//   high nibble first. One symbol slot opens every SYM_DIV clocks.
//
// Handshake: a payload byte is consumed on a clock edge where
//   in_valid && in_ready. in_ready is combinational. It is high only on
//   slot-strobe cycles in PAY_HI. in_valid may change freely while
//   in_ready is low.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           frame request, accepted only in IDLE
//   frame_len       payload byte count, latched at start (0 = preamble only)
//   in_data/valid   payload byte stream, in_ready = byte consumed
//   sym/sym_valid   registered symbol to the mapper, 1-cycle pulse per symbol
//   map_valid       sym_valid delayed one clock (aligned with mapper output)
//   busy            frame in progress
//   underrun        pulse when a payload slot found no byte
//   done            pulse together with the frame's last sym_valid
//   dbg_state       current FSM state (IDLE=0, PREAMBLE=1, PAY_HI=2, PAY_LO=3)
module qam16_frame_scheduler #(
  parameter int          SYM_DIV      = 4,
  parameter int          PREAMBLE_LEN = 8,
  parameter logic [3:0]  PRE_A        = 4'b0000,
  parameter logic [3:0]  PRE_B        = 4'b1111,
  parameter int          LEN_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       sym,
  output logic             sym_valid,
  output logic             map_valid,
  output logic             busy,
  output logic             underrun,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int DIV_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam int PRE_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, PAY_HI = 2'd2, PAY_LO = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic [3:0]       lo_nib;
  logic             strobe;
  logic             emit;      // this strobe produces a symbol
  logic             fin;       // the symbol being emitted is the frame's last
  logic             miss;      // payload slot found no byte
  logic             take;      // payload byte consumed this cycle
  logic [3:0]       sym_nxt;

  // Slot strobe: the divider is cleared on start, so the first strobe lands
  // in the first cycle after start acceptance.
  assign strobe    = (state != IDLE) && (div_cnt == '0);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = PREAMBLE;
      PREAMBLE: if (strobe && (pre_cnt == PRE_LAST))
                  state_nxt = (byte_cnt != '0) ? PAY_HI : IDLE;
      PAY_HI:   if (strobe && in_valid) state_nxt = PAY_LO;
      PAY_LO:   if (strobe) state_nxt = (byte_cnt != '0) ? PAY_HI : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    emit     = 1'b0;
    fin      = 1'b0;
    miss     = 1'b0;
    take     = 1'b0;
    in_ready = 1'b0;
    sym_nxt  = 4'h0;
    case (state)
      PREAMBLE: begin
        emit    = strobe;
        sym_nxt = pre_cnt[0] ? PRE_B : PRE_A;
        fin     = (pre_cnt == PRE_LAST) && (byte_cnt == '0);
      end
      PAY_HI: begin
        in_ready = strobe;
        take     = strobe && in_valid;
        miss     = strobe && !in_valid;
        emit     = take;
        sym_nxt  = in_data[7:4];
      end
      PAY_LO: begin
        emit    = strobe;
        sym_nxt = lo_nib;
        // byte_cnt was already decremented when the high nibble was taken
        fin     = (byte_cnt == '0);
      end
      default: ;
    endcase
  end

  // Counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      pre_cnt   <= '0;
      byte_cnt  <= '0;
      lo_nib    <= 4'h0;
      sym       <= 4'h0;
      sym_valid <= 1'b0;
      map_valid <= 1'b0;
      underrun  <= 1'b0;
      done      <= 1'b0;
    end else begin
      sym_valid <= emit;
      done      <= emit && fin;
      underrun  <= miss;
      map_valid <= sym_valid;
      if (emit) sym <= sym_nxt;
      if (state == IDLE) begin
        div_cnt <= '0;
        if (start) begin
          byte_cnt <= frame_len;
          pre_cnt  <= '0;
        end
      end else begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        if ((state == PREAMBLE) && strobe) pre_cnt <= pre_cnt + 1'b1;
        if (take) begin
          byte_cnt <= byte_cnt - 1'b1;
          lo_nib   <= in_data[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_qam16_frame_scheduler.sv
module tb_qam16_frame_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       start = 1'b0, start2 = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;

  logic       in_ready, sym_valid, map_valid, busy, underrun, done;
  logic [3:0] sym;
  logic [1:0] dbg_state;
  logic       in_ready2, sym_valid2, map_valid2, busy2, underrun2, done2;
  logic [3:0] sym2;
  logic [1:0] dbg_state2;

  qam16_frame_scheduler #(.SYM_DIV(4), .PREAMBLE_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sym(sym), .sym_valid(sym_valid), .map_valid(map_valid), .busy(busy),
    .underrun(underrun), .done(done), .dbg_state(dbg_state)
  );

  qam16_frame_scheduler #(.SYM_DIV(1), .PREAMBLE_LEN(8)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .frame_len(frame_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .sym(sym2), .sym_valid(sym_valid2), .map_valid(map_valid2), .busy(busy2),
    .underrun(underrun2), .done(done2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard state ----------------
  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got_sym[$];
  int sv_cyc[$], mv_cyc[$], done_cyc[$], rdy_cyc[$], und_cyc[$];
  int t0, t1;
  logic [7:0] byte_tab[4] = '{8'hA5, 8'h3C, 8'h00, 8'h00};

  // Event log for the SYM_DIV=4 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (sym_valid) begin
      got_sym.push_back(sym);
      sv_cyc.push_back(cyc);
    end
    if (map_valid) mv_cyc.push_back(cyc);
    if (done)      done_cyc.push_back(cyc);
    if (in_ready)  rdy_cyc.push_back(cyc);
    if (underrun)  und_cyc.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  // Starts a frame (accepted at cycle t0) and runs ncyc cycles. The byte
  // source holds in_valid low for the first 'stalls' offered slots.
  // mid > 0 pulses start at t0+mid. b2b restarts a 0-length frame on the
  // cycle done is seen (its acceptance cycle is recorded in t1).
  task automatic run_frame(input int len, input int stalls, input int mid,
                           input bit b2b, input int ncyc);
    int idx = 0;
    int st = stalls;
    bit b2b_pend = b2b;
    bit fire = 1'b0;
    bit miss = 1'b0;
    got_sym.delete(); sv_cyc.delete(); mv_cyc.delete();
    done_cyc.delete(); rdy_cyc.delete(); und_cyc.delete();
    t1 = -1;
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    frame_len = 8'(len);
    in_data = byte_tab[0];
    in_valid = (st == 0) && (len > 0);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      start = (mid > 0) && (cyc == t0 + mid);
      if (start) frame_len = 8'd5;
      if (fire) idx++;
      if (miss && st > 0) st--;
      in_data = (idx < 4) ? byte_tab[idx] : 8'h00;
      in_valid = (st == 0) && (idx < len);
      @(negedge clk);
      fire = in_ready && in_valid;
      miss = in_ready && !in_valid;
      if (b2b_pend && done) begin
        start = 1'b1;
        frame_len = 8'd0;
        t1 = cyc;
        b2b_pend = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      start2 = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom_range(0, 255));
      frame_len = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk_cnt++;
      if ({sym, sym_valid, map_valid, in_ready, busy, underrun, done,
           sym2, sym_valid2, map_valid2, in_ready2, busy2, underrun2, done2} !== 20'h0)
        $display("FAIL reset_hold cyc=%0d got sym=%h sv=%b mv=%b rdy=%b busy=%b und=%b done=%b / sym2=%h sv2=%b busy2=%b expected all 0",
                 cyc, sym, sym_valid, map_valid, in_ready, busy, underrun, done, sym2, sym_valid2, busy2);
      else pass_cnt++;
    end
    start = 1'b0; start2 = 1'b0; in_valid = 1'b0;
    rst = 1'b1; rst2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_cnt++;
      if ({sym_valid, map_valid, in_ready, busy, underrun, done,
           sym_valid2, busy2, done2} !== 9'h0)
        $display("FAIL reset_idle cyc=%0d got sv=%b mv=%b rdy=%b busy=%b und=%b done=%b busy2=%b expected all 0",
                 cyc, sym_valid, map_valid, in_ready, busy, underrun, done, busy2);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    exp_q = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hA, 4'h5, 4'h3, 4'hC};
    run_frame(2, 0, 0, 1'b0, 55);
    chk_cnt++;
    if (got_sym.size() != exp_q.size())
      $display("FAIL basic_count got=%0d expected=%0d", got_sym.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_sym.size())
        $display("FAIL basic_sym%0d missing expected=%h", i, exp_q[i]);
      else if (got_sym[i] !== exp_q[i] || sv_cyc[i] != t0 + 2 + 4 * i)
        $display("FAIL basic_sym%0d got=%h@%0d expected=%h@%0d", i, got_sym[i], sv_cyc[i] - t0, exp_q[i], 2 + 4 * i);
      else pass_cnt++;
    end
    chk_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != t0 + 46)
      $display("FAIL basic_done got count=%0d first=%0d expected 1 at %0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, 46);
    else pass_cnt++;
    chk_cnt++;
    if (rdy_cyc.size() != 2 || rdy_cyc[0] != t0 + 33 || rdy_cyc[1] != t0 + 41)
      $display("FAIL basic_in_ready got count=%0d expected 2 at 33,41", rdy_cyc.size());
    else pass_cnt++;
    chk_cnt++;
    if (mv_cyc.size() != sv_cyc.size())
      $display("FAIL basic_map_valid_count got=%0d expected=%0d", mv_cyc.size(), sv_cyc.size());
    else begin
      bit ok = 1'b1;
      for (int i = 0; i < mv_cyc.size(); i++) if (mv_cyc[i] != sv_cyc[i] + 1) ok = 1'b0;
      if (!ok) $display("FAIL basic_map_valid_align got misaligned expected sym_valid+1");
      else pass_cnt++;
    end
    chk_cnt++;
    if (busy !== 1'b0 || und_cyc.size() != 0)
      $display("FAIL basic_end got busy=%b underruns=%0d expected busy=0 underruns=0", busy, und_cyc.size());
    else pass_cnt++;
  endtask

  task automatic test_underrun();
    exp_q = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hA, 4'h5, 4'h3, 4'hC};
    run_frame(2, 2, 0, 1'b0, 62);
    chk_cnt++;
    if (und_cyc.size() != 2 || und_cyc[0] != t0 + 34 || und_cyc[1] != t0 + 38)
      $display("FAIL under_pulses got count=%0d expected 2 at 34,38", und_cyc.size());
    else pass_cnt++;
    chk_cnt++;
    if (got_sym.size() != exp_q.size())
      $display("FAIL under_count got=%0d expected=%0d", got_sym.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      int ec = t0 + 2 + 4 * i + ((i >= 8) ? 8 : 0);
      chk_cnt++;
      if (i >= got_sym.size())
        $display("FAIL under_sym%0d missing expected=%h", i, exp_q[i]);
      else if (got_sym[i] !== exp_q[i] || sv_cyc[i] != ec)
        $display("FAIL under_sym%0d got=%h@%0d expected=%h@%0d", i, got_sym[i], sv_cyc[i] - t0, exp_q[i], ec - t0);
      else pass_cnt++;
    end
    chk_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != t0 + 54 || rdy_cyc.size() != 4)
      $display("FAIL under_done got dones=%0d ready_pulses=%0d expected 1 done at 54, 4 ready", done_cyc.size(), rdy_cyc.size());
    else pass_cnt++;
  endtask

  task automatic test_preamble_only();
    run_frame(0, 0, 0, 1'b0, 40);
    chk_cnt++;
    if (got_sym.size() != 8)
      $display("FAIL pre_only_count got=%0d expected=8", got_sym.size());
    else pass_cnt++;
    for (int i = 0; i < 8 && i < got_sym.size(); i++) begin
      chk_cnt++;
      if (got_sym[i] !== ((i % 2) ? 4'hF : 4'h0) || sv_cyc[i] != t0 + 2 + 4 * i)
        $display("FAIL pre_only_sym%0d got=%h@%0d expected=%h@%0d", i, got_sym[i], sv_cyc[i] - t0,
                 (i % 2) ? 4'hF : 4'h0, 2 + 4 * i);
      else pass_cnt++;
    end
    chk_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != t0 + 30 || rdy_cyc.size() != 0)
      $display("FAIL pre_only_done got dones=%0d ready_pulses=%0d expected 1 done at 30, 0 ready", done_cyc.size(), rdy_cyc.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0, 10, 1'b1, 70);
    chk_cnt++;
    if (t1 != t0 + 30)
      $display("FAIL b2b_restart got restart at %0d expected %0d", t1 - t0, 30);
    else pass_cnt++;
    chk_cnt++;
    if (got_sym.size() != 16)
      $display("FAIL b2b_count got=%0d expected=16", got_sym.size());
    else pass_cnt++;
    for (int i = 0; i < 16 && i < got_sym.size(); i++) begin
      int ec = (i < 8) ? t0 + 2 + 4 * i : t0 + 30 + 2 + 4 * (i - 8);
      chk_cnt++;
      if (got_sym[i] !== ((i % 2) ? 4'hF : 4'h0) || sv_cyc[i] != ec)
        $display("FAIL b2b_sym%0d got=%h@%0d expected=%h@%0d", i, got_sym[i], sv_cyc[i] - t0,
                 (i % 2) ? 4'hF : 4'h0, ec - t0);
      else pass_cnt++;
    end
    chk_cnt++;
    if (done_cyc.size() != 2 || done_cyc[0] != t0 + 30 || done_cyc[1] != t0 + 60 || rdy_cyc.size() != 0)
      $display("FAIL b2b_done got dones=%0d ready_pulses=%0d expected 2 dones at 30,60, 0 ready", done_cyc.size(), rdy_cyc.size());
    else pass_cnt++;
  endtask

  task automatic test_sym_div1_reset();
    int base;
    int ndone = 0;
    @(posedge clk); #1;
    frame_len = 8'd3; in_data = 8'hA5; in_valid = 1'b1;
    @(negedge clk);
    base = cyc; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      int idx = c - 2;
      logic [3:0] es;
      @(negedge clk);
      es = (idx < 8) ? ((idx % 2) ? 4'hF : 4'h0) : ((idx % 2) ? 4'h5 : 4'hA);
      chk_cnt++;
      if (sym_valid2 !== (c >= 2) || (c >= 2 && sym2 !== es) || done2 !== 1'b0)
        $display("FAIL div1_cyc%0d got sv=%b sym=%h done=%b expected sv=%b sym=%h done=0", c, sym_valid2, sym2, done2, (c >= 2), es);
      else pass_cnt++;
    end
    // Reset in the middle of the payload.
    rst2 = 1'b0;
    #1;
    chk_cnt++;
    if ({sym2, sym_valid2, map_valid2, in_ready2, busy2, underrun2, done2} !== 10'h0)
      $display("FAIL div1_midreset got sym=%h sv=%b mv=%b rdy=%b busy=%b und=%b done=%b expected all 0",
               sym2, sym_valid2, map_valid2, in_ready2, busy2, underrun2, done2);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done2) ndone++;
    end
    rst2 = 1'b1;
    @(negedge clk);
    if (done2) ndone++;
    chk_cnt++;
    if (ndone != 0 || busy2 !== 1'b0)
      $display("FAIL div1_no_done got dones=%0d busy=%b expected 0 dones busy=0", ndone, busy2);
    else pass_cnt++;
    // Fresh one-byte frame after release.
    frame_len = 8'd1;
    start2 = 1'b1;
    base = cyc;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      int idx = c - 2;
      logic [3:0] es;
      logic ev;
      @(negedge clk);
      ev = (c >= 2) && (c <= 11);
      es = (idx < 8) ? ((idx % 2) ? 4'hF : 4'h0) : ((idx % 2) ? 4'h5 : 4'hA);
      chk_cnt++;
      if (sym_valid2 !== ev || (ev && sym2 !== es) || done2 !== (c == 11))
        $display("FAIL div1_refr_cyc%0d got sv=%b sym=%h done=%b expected sv=%b sym=%h done=%b",
                 c, sym_valid2, sym2, done2, ev, es, (c == 11));
      else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_preamble_only();
    test_back_to_back();
    test_sym_div1_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
